// File: rtl/lsu_queue_if.sv
// Bundle of the issue-side, forwarding, DCache-side and completion signals of lsu_queue.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1; valid never waits on ready.
interface lsu_queue_if #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int NUM_FWD = 2,
  parameter int DEP_W   = 2
);
  logic                        in_valid;
  logic                        in_ready;
  logic [5:0]                  ex_type;
  logic [4:0]                  rd;
  logic [XLEN:0]               data1;
  logic [XLEN:0]               data2;
  logic [XLEN:0]               imm_ex;
  logic [DEP_W-1:0]            data1_depend;
  logic [DEP_W-1:0]            write_data_depend;
  logic [NUM_FWD*(XLEN+1)-1:0] fwd_data;
  logic                        req_valid;
  logic                        req_ready;
  logic                        req_we;
  logic [XLEN-1:0]             addr;
  logic [XLEN-1:0]             wdata;
  logic [XLEN/8-1:0]           wstrb;
  logic                        mem_done;
  logic [XLEN-1:0]             DCache_data;
  logic                        done;
  logic [4:0]                  rd_out;
  logic [XLEN-1:0]             result;
  logic                        err;
  logic [$clog2(DEPTH):0]      count;
  logic [1:0]                  head_state;

  modport slave (
    input  in_valid, ex_type, rd, data1, data2, imm_ex, data1_depend, write_data_depend,
    input  fwd_data, req_ready, mem_done, DCache_data,
    output in_ready, req_valid, req_we, addr, wdata, wstrb, done, rd_out, result, err,
    output count, head_state
  );

  modport master (
    output in_valid, ex_type, rd, data1, data2, imm_ex, data1_depend, write_data_depend,
    output fwd_data, req_ready, mem_done, DCache_data,
    input  in_ready, req_valid, req_we, addr, wdata, wstrb, done, rd_out, result, err,
    input  count, head_state
  );
endinterface

// File: rtl/lsu_queue.sv
// In-order load/store queue: captures operands from issue or forwarding buses,
// then issues one aligned DCache request at a time from the head entry.
module lsu_queue #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int NUM_FWD = 2,
  parameter int DEP_W   = 2
) (
  input logic        clk,
  input logic        rst,
  lsu_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int NB = XLEN / 8;
  localparam int FW = NUM_FWD * (XLEN + 1);

  localparam logic [5:0] OP_LB  = 6'd21;
  localparam logic [5:0] OP_LH  = 6'd22;
  localparam logic [5:0] OP_LW  = 6'd23;
  localparam logic [5:0] OP_LBU = 6'd24;
  localparam logic [5:0] OP_LHU = 6'd25;
  localparam logic [5:0] OP_SB  = 6'd26;
  localparam logic [5:0] OP_SH  = 6'd27;
  localparam logic [5:0] OP_SW  = 6'd28;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  typedef struct packed {
    logic             valid;
    logic [5:0]       op;
    logic [4:0]       rd;
    logic             base_ok;
    logic [DEP_W-1:0] base_dep;
    logic [XLEN-1:0]  base;
    logic             sd_ok;
    logic [DEP_W-1:0] sd_dep;
    logic [XLEN-1:0]  sd;
    logic             imm_ok;
    logic [XLEN-1:0]  imm;
  } entry_t;

  state_t          state, state_nxt;
  entry_t          q [DEPTH];
  entry_t          new_e;
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   cnt;
  logic            push, pop, req_v;
  logic [XLEN:0]   base_cap [DEPTH];
  logic [XLEN:0]   sd_cap [DEPTH];
  logic [XLEN:0]   in_base, in_sd;
  logic [5:0]      h_op;
  logic [4:0]      h_rd;
  logic [XLEN-1:0] h_sd, eff, shifted, load_val, wd, res_q;
  logic [NB-1:0]   ws;
  logic [1:0]      off;
  logic            h_store, h_ready, h_mis, err_q;

  // Dependency k selects bus k-1; 0 and anything above NUM_FWD never match.
  function automatic logic [XLEN:0] fwd_pick(input logic [FW-1:0] f, input logic [DEP_W-1:0] dep);
    fwd_pick = '0;
    for (int k = 0; k < NUM_FWD; k++)
      if (int'(dep) == k + 1) fwd_pick = f[k*(XLEN+1) +: XLEN+1];
  endfunction

  assign push         = bus.in_valid && bus.in_ready;
  assign bus.in_ready = (cnt != CW'(DEPTH));

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      base_cap[i] = fwd_pick(bus.fwd_data, q[i].base_dep);
      sd_cap[i]   = fwd_pick(bus.fwd_data, q[i].sd_dep);
    end
  end

  always_comb begin
    new_e        = '0;
    in_base      = fwd_pick(bus.fwd_data, bus.data1_depend);
    in_sd        = fwd_pick(bus.fwd_data, bus.write_data_depend);
    new_e.valid  = 1'b1;
    new_e.op     = bus.ex_type;
    new_e.rd     = bus.rd;
    new_e.imm    = bus.imm_ex[XLEN-1:0];
    new_e.imm_ok = bus.imm_ex[XLEN];
    if (bus.data1_depend == '0) begin
      new_e.base    = bus.data1[XLEN-1:0];
      new_e.base_ok = bus.data1[XLEN];
    end else if (in_base[XLEN]) begin
      new_e.base    = in_base[XLEN-1:0];
      new_e.base_ok = 1'b1;
    end else begin
      new_e.base_dep = bus.data1_depend;
    end
    if (bus.write_data_depend == '0) begin
      new_e.sd    = bus.data2[XLEN-1:0];
      new_e.sd_ok = bus.data2[XLEN];
    end else if (in_sd[XLEN]) begin
      new_e.sd    = in_sd[XLEN-1:0];
      new_e.sd_ok = 1'b1;
    end else begin
      new_e.sd_dep = bus.write_data_depend;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q[i].valid && !q[i].base_ok && base_cap[i][XLEN]) begin
          q[i].base     <= base_cap[i][XLEN-1:0];
          q[i].base_ok  <= 1'b1;
          q[i].base_dep <= '0;
        end
        if (q[i].valid && !q[i].sd_ok && sd_cap[i][XLEN]) begin
          q[i].sd     <= sd_cap[i][XLEN-1:0];
          q[i].sd_ok  <= 1'b1;
          q[i].sd_dep <= '0;
        end
      end
      if (pop) q[head].valid <= 1'b0;
      if (push) q[tail] <= new_e;
      if (pop) head <= head + 1'b1;
      if (push) tail <= tail + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  assign h_op    = q[head].op;
  assign h_rd    = q[head].rd;
  assign h_sd    = q[head].sd;
  assign eff     = q[head].base + q[head].imm;
  assign off     = eff[1:0];
  assign h_store = (h_op == OP_SB) || (h_op == OP_SH) || (h_op == OP_SW);
  assign h_ready = q[head].valid && q[head].base_ok && q[head].imm_ok && (!h_store || q[head].sd_ok);
  assign h_mis   = (((h_op == OP_LH) || (h_op == OP_LHU) || (h_op == OP_SH)) && off[0]) ||
                   (((h_op == OP_LW) || (h_op == OP_SW)) && (off != 2'b00));

  assign shifted = bus.DCache_data >> {off, 3'b000};
  always_comb begin
    case (h_op)
      OP_LB:   load_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      OP_LBU:  load_val = {{(XLEN-8){1'b0}}, shifted[7:0]};
      OP_LH:   load_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      OP_LHU:  load_val = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // Byte/halfword stores replicate the datum so every lane carries it; the strobes pick the lane.
  always_comb begin
    case (h_op)
      OP_SB: begin
        wd = {NB{h_sd[7:0]}};
        ws = NB'(1) << off;
      end
      OP_SH: begin
        wd = {(XLEN/16){h_sd[15:0]}};
        ws = NB'(3) << off;
      end
      default: begin
        wd = h_sd;
        ws = '1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // IDLE raises the request combinationally so a ready entry issues the cycle after enqueue.
  always_comb begin
    state_nxt = state;
    req_v     = 1'b0;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (h_ready) begin
          if (h_mis) begin
            state_nxt = S_DONE;
          end else begin
            req_v     = 1'b1;
            state_nxt = bus.req_ready ? S_WAIT : S_REQ;
          end
        end
      end
      S_REQ: begin
        req_v = 1'b1;
        if (bus.req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: if (bus.mem_done) state_nxt = S_DONE;
      S_DONE: begin
        pop       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      err_q <= 1'b0;
    end else if (state == S_IDLE && h_ready && h_mis) begin
      res_q <= '0;
      err_q <= 1'b1;
    end else if (state == S_WAIT && bus.mem_done) begin
      res_q <= h_store ? '0 : load_val;
      err_q <= 1'b0;
    end
  end

  assign bus.req_valid  = req_v;
  assign bus.req_we     = req_v && h_store;
  assign bus.addr       = req_v ? {eff[XLEN-1:2], 2'b00} : '0;
  assign bus.wdata      = (req_v && h_store) ? wd : '0;
  assign bus.wstrb      = (req_v && h_store) ? ws : '0;
  assign bus.done       = (state == S_DONE);
  assign bus.err        = bus.done && err_q;
  assign bus.result     = bus.done ? res_q : '0;
  assign bus.rd_out     = (bus.done && !err_q && !h_store) ? h_rd : '0;
  assign bus.count      = cnt;
  assign bus.head_state = state;
endmodule

// File: tb/tb_lsu_queue.sv
// Directed bench for lsu_queue: loads/stores, lane handling, forwarding, fill, misalignment, reset.
module tb_lsu_queue;
  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam int NUM_FWD = 2;
  localparam int DEP_W = 2;

  logic clk = 1'b0;
  logic rst;
  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  lsu_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_FWD(NUM_FWD), .DEP_W(DEP_W)) bus();
  lsu_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_FWD(NUM_FWD), .DEP_W(DEP_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] v(input logic [31:0] x);
    return {1'b1, x};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [5:0] t, input logic [4:0] r, input logic [32:0] d1,
                     input logic [32:0] d2, input logic [32:0] im, input logic [1:0] dp1,
                     input logic [1:0] dpw);
    bus.in_valid = 1'b1;
    bus.ex_type = t;
    bus.rd = r;
    bus.data1 = d1;
    bus.data2 = d2;
    bus.imm_ex = im;
    bus.data1_depend = dp1;
    bus.write_data_depend = dpw;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic serve(input logic [31:0] rdata);
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    bus.mem_done = 1'b1;
    bus.DCache_data = rdata;
    tick();
    bus.mem_done = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int c = 0; c < 20 && bus.req_valid !== 1'b1; c++) tick();
    check_eq(tag, bus.req_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 0; bus.ex_type = 0; bus.rd = 0; bus.data1 = 0; bus.data2 = 0;
    bus.imm_ex = 0; bus.data1_depend = 0; bus.write_data_depend = 0; bus.fwd_data = '0;
    bus.req_ready = 0; bus.mem_done = 0; bus.DCache_data = 0;
    repeat (2) tick();
    rst = 1'b0;
    check_eq("rst_count", bus.count, 0);
    check_eq("rst_in_ready", bus.in_ready, 1);
    check_eq("rst_req_valid", bus.req_valid, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_state", bus.head_state, 0);

    // LW 0x1000+8
    enq(6'd23, 5'd5, v(32'h1000), 33'd0, v(32'd8), 2'd0, 2'd0);
    check_eq("lw_req_valid", bus.req_valid, 1);
    check_eq("lw_addr", bus.addr, 32'h1008);
    check_eq("lw_we", bus.req_we, 0);
    check_eq("lw_count", bus.count, 1);
    serve(32'hDEADBEEF);
    check_eq("lw_done", bus.done, 1);
    check_eq("lw_result", bus.result, 32'hDEADBEEF);
    check_eq("lw_rd", bus.rd_out, 5);
    check_eq("lw_err", bus.err, 0);
    tick();
    check_eq("lw_done_pulse", bus.done, 0);
    check_eq("lw_result_idle", bus.result, 0);
    check_eq("lw_count_end", bus.count, 0);

    // LB / LBU / LH at lanes 3 and 2
    enq(6'd21, 5'd6, v(32'h1000), 33'd0, v(32'd3), 2'd0, 2'd0);
    check_eq("lb_addr", bus.addr, 32'h1000);
    serve(32'h80FF_0000);
    check_eq("lb_result", bus.result, 32'hFFFF_FF80);
    tick();
    enq(6'd24, 5'd6, v(32'h1000), 33'd0, v(32'd3), 2'd0, 2'd0);
    serve(32'h80FF_0000);
    check_eq("lbu_result", bus.result, 32'h0000_0080);
    tick();
    enq(6'd22, 5'd4, v(32'h1000), 33'd0, v(32'd2), 2'd0, 2'd0);
    serve(32'h8001_0000);
    check_eq("lh_result", bus.result, 32'hFFFF_8001);
    tick();

    // SH at 0x2002, SB at 0x3001
    enq(6'd27, 5'd9, v(32'h2000), v(32'h1234_ABCD), v(32'd2), 2'd0, 2'd0);
    check_eq("sh_we", bus.req_we, 1);
    check_eq("sh_addr", bus.addr, 32'h2000);
    check_eq("sh_wstrb", bus.wstrb, 4'b1100);
    check_eq("sh_wdata", bus.wdata, 32'hABCD_ABCD);
    serve(32'h0);
    check_eq("sh_done", bus.done, 1);
    check_eq("sh_rd", bus.rd_out, 0);
    check_eq("sh_result", bus.result, 0);
    tick();
    enq(6'd26, 5'd9, v(32'h3000), v(32'h0000_0055), v(32'd1), 2'd0, 2'd0);
    check_eq("sb_wstrb", bus.wstrb, 4'b0010);
    check_eq("sb_wdata", bus.wdata, 32'h5555_5555);
    serve(32'h0);
    tick();

    // base waits on forwarding source 0
    bus.fwd_data = '0;
    enq(6'd23, 5'd7, {1'b0, 32'h0}, 33'd0, v(32'h10), 2'd1, 2'd0);
    for (int c = 0; c < 3; c++) begin
      check_eq("fwd_stall", bus.req_valid, 0);
      tick();
    end
    bus.fwd_data = {33'd0, 1'b1, 32'h40};
    #1;
    check_eq("fwd_capture_cycle", bus.req_valid, 0);
    tick();
    bus.fwd_data = '0;
    check_eq("fwd_req_valid", bus.req_valid, 1);
    check_eq("fwd_addr", bus.addr, 32'h50);
    serve(32'h1);
    check_eq("fwd_rd", bus.rd_out, 7);
    tick();

    // fill the queue while the DCache stalls
    for (int i = 0; i < 4; i++) begin
      enq(6'd23, 5'(10 + i), v(32'(i * 256)), 33'd0, v(32'd0), 2'd0, 2'd0);
      exp_q.push_back(5'(10 + i));
    end
    check_eq("full_count", bus.count, 4);
    check_eq("full_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    bus.rd = 5'd31;
    tick();
    bus.in_valid = 1'b0;
    check_eq("full_no_push", bus.count, 4);
    for (int i = 0; i < 4; i++) begin
      wait_req("fill_req");
      check_eq("fill_addr", bus.addr, 32'(i * 256));
      serve(32'(32'h1000 + i));
      check_eq("fill_done", bus.done, 1);
      check_eq("fill_rd", bus.rd_out, exp_q.pop_front());
      check_eq("fill_result", bus.result, 32'(32'h1000 + i));
      tick();
    end
    check_eq("drain_count", bus.count, 0);
    check_eq("drain_in_ready", bus.in_ready, 1);

    // misaligned LW, then an aligned one behind it
    enq(6'd23, 5'd8, v(32'h1000), 33'd0, v(32'd2), 2'd0, 2'd0);
    check_eq("mis_noreq", bus.req_valid, 0);
    enq(6'd23, 5'd9, v(32'h1000), 33'd0, v(32'd4), 2'd0, 2'd0);
    check_eq("mis_done", bus.done, 1);
    check_eq("mis_err", bus.err, 1);
    check_eq("mis_rd", bus.rd_out, 0);
    check_eq("mis_result", bus.result, 0);
    check_eq("mis_noreq_done", bus.req_valid, 0);
    tick();
    check_eq("next_req", bus.req_valid, 1);
    check_eq("next_addr", bus.addr, 32'h1004);
    serve(32'h77);
    check_eq("next_done", bus.done, 1);
    check_eq("next_err", bus.err, 0);
    check_eq("next_rd", bus.rd_out, 9);
    check_eq("next_result", bus.result, 32'h77);
    tick();

    // reset while waiting on the DCache
    enq(6'd23, 5'd3, v(32'h500), 33'd0, v(32'd0), 2'd0, 2'd0);
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    check_eq("wait_state", bus.head_state, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst2_req_valid", bus.req_valid, 0);
    check_eq("rst2_done", bus.done, 0);
    check_eq("rst2_rd", bus.rd_out, 0);
    check_eq("rst2_result", bus.result, 0);
    check_eq("rst2_err", bus.err, 0);
    check_eq("rst2_count", bus.count, 0);
    check_eq("rst2_wstrb", bus.wstrb, 0);
    check_eq("rst2_wdata", bus.wdata, 0);
    check_eq("rst2_state", bus.head_state, 0);
    bus.mem_done = 1'b1;
    bus.DCache_data = 32'hFFFF;
    tick();
    bus.mem_done = 1'b0;
    check_eq("late_mem_done", bus.done, 0);
    tick();
    check_eq("late_mem_done2", bus.done, 0);
    check_eq("late_count", bus.count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
